// File: rtl/rad_cdc_mcp_bload_arb_if.sv
// ---------------------------------------------------------------------------
// rad_cdc_mcp_bload_arb_if
//
// Bundle of the request / MCP-receiver / delivery signals of the bload
// arbiter. Everything here lives in the receive (bclk) domain.
//
//   req        NREQ        level request per consumer
//   bvalid     1           MCP receiver holds an unconsumed word
//   bdata      WIDTH       MCP receiver captured data
//   bload      1           load strobe to the MCP receiver
//   rsp_valid  NREQ        one-hot 1-cycle delivery strobe
//   rsp_data   WIDTH       delivered word, valid with rsp_valid
//   gnt_id     $clog2(NREQ) index of the last grant
//   busy       1           arbiter FSM not idle
//   drop       1           1-cycle pulse when a word is drained
//   drop_cnt   CNTW        saturating count of drained words
//
// Modports:
//   slave  - the arbiter side (consumes req/bvalid/bdata)
//   master - the environment side (drives req/bvalid/bdata)
// ---------------------------------------------------------------------------
interface rad_cdc_mcp_bload_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CNTW  = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic             bvalid;
    logic [WIDTH-1:0] bdata;
    logic             bload;
    logic [NREQ-1:0]  rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [IW-1:0]    gnt_id;
    logic             busy;
    logic             drop;
    logic [CNTW-1:0]  drop_cnt;

    modport slave (
        input  req, bvalid, bdata,
        output bload, rsp_valid, rsp_data, gnt_id, busy, drop, drop_cnt
    );

    modport master (
        output req, bvalid, bdata,
        input  bload, rsp_valid, rsp_data, gnt_id, busy, drop, drop_cnt
    );
endinterface

// File: rtl/rad_cdc_mcp_bload_arb.sv
// ---------------------------------------------------------------------------
// rad_cdc_mcp_bload_arb
//
// Round-robin arbiter sharing one MCP receive channel among NREQ consumers.
// When the receiver holds a word (bvalid) and at least one consumer requests,
// the arbiter pulses bload, commits the grant, and two cycles later delivers
// the captured bdata to the winner with a one-hot rsp_valid strobe. Words
// nobody claims for TIMEOUT cycles are loaded and discarded (drop pulse,
// saturating drop_cnt) so the sender never stalls. TIMEOUT=0 never drains.
//
// Ports:
//   clk   receive-domain clock (bclk)
//   rst   asynchronous active-high reset
//   bus   rad_cdc_mcp_bload_arb_if.slave: req/bvalid/bdata in,
//         bload/rsp_valid/rsp_data/gnt_id/busy/drop/drop_cnt out
// ---------------------------------------------------------------------------
module rad_cdc_mcp_bload_arb #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    rad_cdc_mcp_bload_arb_if.slave    bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DLVR,
        DRAIN,
        WAIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   winner;
    logic            win_found;
    int unsigned     idx;
    logic [TW-1:0]   tcnt;
    logic [CNTW-1:0] drop_cnt;
    logic            any_req;
    logic            expired;
    logic            bload_fsm;

    assign any_req = |bus.req;
    assign expired = (TIMEOUT != 0) && (tcnt == TLAST);

    // First asserted request at or after the RR pointer, wrapping modulo NREQ.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && bus.req[IW'(idx)]) begin
                win_found = 1'b1;
                winner    = IW'(idx);
            end
        end
    end

    // Next state and bload. A request present in the expiry cycle takes
    // priority over the drain.
    always_comb begin
        state_nxt = state;
        bload_fsm = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bvalid && any_req) begin
                    state_nxt = LOAD;
                    bload_fsm = 1'b1;
                end else if (bus.bvalid && expired) begin
                    state_nxt = DRAIN;
                    bload_fsm = 1'b1;
                end
            end
            LOAD:    state_nxt = DLVR;
            DLVR:    state_nxt = WAIT;
            DRAIN:   state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            tcnt     <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && state_nxt == LOAD) begin
                gnt_id <= winner;
            end

            if (state == DLVR) begin
                rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + IW'(1);
            end

            if (state == DRAIN && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNTW'(1);
            end

            // Counts only while an unclaimed word waits in IDLE; any exit
            // from IDLE (including the drain itself) clears it.
            if (TIMEOUT != 0 && state == IDLE && state_nxt == IDLE &&
                bus.bvalid && !any_req) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end

    // bload is combinational; masking with rst keeps every output at zero
    // while reset is held even if bvalid and req are already high.
    assign bus.bload     = bload_fsm && !rst;
    assign bus.rsp_valid = (state == DLVR) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
    assign bus.rsp_data  = (state == DLVR) ? bus.bdata : '0;
    assign bus.gnt_id    = gnt_id;
    assign bus.busy      = (state != IDLE);
    assign bus.drop      = (state == DRAIN);
    assign bus.drop_cnt  = drop_cnt;

endmodule
